alu_bist_ctrl: RTL

Built-in self-test controller for ALU_Main. It drives the ALU operand and opcode inputs with pseudo-random vectors and cycles through all eight opcodes. It compresses every ALU result and flag set into a 32-bit MISR signature, then compares that signature against a golden value. It sits beside the ALU in the 16-bit core and owns the ALU inputs while busy; the core muxes it in for production and power-on test.

---
 rtl/alu_bist_pkg.sv | 29 ++
 rtl/bist_lfsr16.sv | 24 ++
 rtl/alu_bist_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test controller:
// FSM encoding, LFSR/MISR polynomials, ALU opcodes and the MISR step.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_SAMPLE = 2'b10,
    ST_DONE   = 2'b11
  } bist_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AGB = 3'b101;
  localparam logic [2:0] OP_BGA = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  // One MISR compression step: shift left, fold back the polynomial, absorb data.
  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] data);
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ data;
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit right-shifting Galois LFSR used as a pseudo-random operand source.
module bist_lfsr16
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  // An all-zero state would lock up the register, so a zero seed loads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (step) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST controller for ALU_Main: drives pseudo-random operands through all
// opcodes, compresses results and flags into a MISR and compares to a golden value.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] SEED_A        = 16'hACE1,
  parameter logic [15:0] SEED_B        = 16'h1D2B,
  parameter logic [31:0] GOLDEN_SIG    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] sig_out,
  output logic [15:0] vec_count,
  output logic [15:0] alu_d_in_1,
  output logic [15:0] alu_d_in_2,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_d_out,
  input  logic        alu_z_flag,
  input  logic        alu_a_grt_b,
  input  logic        alu_b_grt_a
);

  localparam logic [16:0] LAST_COUNT  = 17'(NUM_VECTORS);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

  bist_state_t state;
  logic [31:0] settle_cnt;
  logic [31:0] misr;
  logic [31:0] sample_data;
  logic [31:0] misr_new;
  logic        start_ok;
  logic        last_vec;
  logic        lfsr_load;
  logic        lfsr_step;

  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_vec    = (({1'b0, vec_count} + 17'd1) == LAST_COUNT);
  assign sample_data = alu_d_out ^ {29'b0, alu_z_flag, alu_a_grt_b, alu_b_grt_a};
  assign misr_new    = misr_next(misr, sample_data);
  assign lfsr_load   = start_ok;
  assign lfsr_step   = (state == ST_SAMPLE) && !last_vec;
  assign sig_out     = misr;

  bist_lfsr16 u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_A),
    .step (lfsr_step),
    .q    (alu_d_in_1)
  );

  bist_lfsr16 u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_B),
    .step (lfsr_step),
    .q    (alu_d_in_2)
  );

  // Each vector is held for SETTLE_CYCLES in WAIT, then captured on the SAMPLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      misr       <= '0;
      vec_count  <= '0;
      alu_op     <= OP_ADD;
      settle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            misr       <= '0;
            vec_count  <= '0;
            alu_op     <= OP_ADD;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (settle_cnt == 32'd0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 32'd1;
          end
        end
        ST_SAMPLE: begin
          misr      <= misr_new;
          vec_count <= vec_count + 16'd1;
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (misr_new == GOLDEN_SIG);
            state <= ST_DONE;
          end else begin
            alu_op     <= vec_count[2:0] + 3'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
